// File: rtl/mips_pkg.sv
// mips_pkg: shared size encodings, MEM-stage FSM states and datapath width.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory req/gnt/rvalid bus between the MEM stage and data memory.
interface mem_access_stage_if #(parameter int ADDR_W = 32);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [31:0]       dmem_rdata;
    modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                    input dmem_gnt, dmem_rvalid, dmem_rdata);
    modport slave (input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                   output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/mem_access_stage_lane.sv
// mem_lane_align: store lane steering, load extraction/extension and misalignment detection.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              mem_unsigned,
    input  logic              is_store,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic              misalign
);
    logic [DATA_W-1:0] sh;
    always_comb begin
        sh = rdata >> {addr_lo, 3'b000};
        misalign = (size == SZ_HALF && addr_lo[0]) || (size >= SZ_WORD && addr_lo != 2'b00);
        be = !is_store ? 4'hf :
             size == SZ_BYTE ? 4'b0001 << addr_lo :
             size == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'hf;
        wdata = size == SZ_BYTE ? {4{store_data[7:0]}} :
                size == SZ_HALF ? {2{store_data[15:0]}} : store_data;
        load_data = size == SZ_BYTE ? {{24{~mem_unsigned & sh[7]}}, sh[7:0]} :
                    size == SZ_HALF ? {{16{~mem_unsigned & sh[15]}}, sh[15:0]} : sh;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage issuing variable-latency data-memory accesses and stalling upstream.
module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               MemToReg,
    input  logic               RegWrite,
    input  logic [1:0]         mem_size,
    input  logic               mem_unsigned,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [DATA_W-1:0]  store_data,
    input  logic [4:0]         write_reg,
    mem_access_stage_if.master dmem,
    output logic               MemToReg_o,
    output logic               RegWrite_o,
    output logic               MemWrite_o,
    output logic [DATA_W-1:0]  mem_read_data_o,
    output logic [DATA_W-1:0]  alu_result_o,
    output logic [4:0]         write_reg_o,
    output logic [DATA_W-1:0]  store_data_o,
    output logic               stall_o,
    output logic               misalign_o
);
    import mips_pkg::*;
    state_t state, state_n;
    logic [DATA_W-1:0] rdata_q, wdata, load_data, rd;
    logic [3:0] be;
    logic misal, mem_op, go, req, stall, pass, on;
    mem_lane_align u_lane (
        .addr_lo(alu_result[1:0]),
        .size(mem_size),
        .mem_unsigned(mem_unsigned),
        .is_store(MemWrite),
        .store_data(store_data),
        .rdata(rdata_q),
        .be(be),
        .wdata(wdata),
        .load_data(load_data),
        .misalign(misal)
    );
    assign on = ~reset;
    assign mem_op = ex_valid & (MemRead | MemWrite);
    assign go = mem_op & ~misal;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (state == WAIT && dmem.dmem_rvalid) rdata_q <= dmem.dmem_rdata;
        end
    end
    // Every stalled cycle presents a bubble; only IDLE passthrough and DONE carry controls.
    always_comb begin
        state_n = state;
        req = 1'b0;
        stall = 1'b0;
        pass = 1'b0;
        rd = '0;
        case (state)
            IDLE: begin
                req = go;
                stall = go;
                pass = ~mem_op;
                state_n = go ? (dmem.dmem_gnt ? WAIT : REQ) : IDLE;
            end
            REQ: begin
                req = 1'b1;
                stall = 1'b1;
                state_n = dmem.dmem_gnt ? WAIT : REQ;
            end
            WAIT: begin
                stall = 1'b1;
                state_n = dmem.dmem_rvalid ? DONE : WAIT;
            end
            default: begin
                pass = 1'b1;
                rd = load_data;
                state_n = IDLE;
            end
        endcase
    end
    assign dmem.dmem_req   = on & req;
    assign dmem.dmem_we    = on & req & MemWrite;
    assign dmem.dmem_addr  = on ? {alu_result[ADDR_W-1:2], 2'b00} : '0;
    assign dmem.dmem_be    = on ? be : 4'h0;
    assign dmem.dmem_wdata = on ? wdata : '0;
    assign MemToReg_o      = on & pass & ex_valid & MemToReg;
    assign RegWrite_o      = on & pass & ex_valid & RegWrite;
    assign MemWrite_o      = on & pass & ex_valid & MemWrite;
    assign mem_read_data_o = on ? rd : '0;
    assign alu_result_o    = on ? alu_result : '0;
    assign write_reg_o     = on ? write_reg : 5'd0;
    assign store_data_o    = on ? wdata : '0;
    assign stall_o         = on & stall;
    assign misalign_o      = on & (state == IDLE) & mem_op & misal;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench for the MEM stage with an inline memory responder.
module tb_mem_access_stage;
    import mips_pkg::*;
    logic clk = 1'b0;
    logic reset, ex_valid, MemRead, MemWrite, MemToReg, RegWrite, mem_unsigned;
    logic [1:0] mem_size;
    logic [31:0] alu_result, store_data;
    logic [4:0] write_reg;
    logic MemToReg_o, RegWrite_o, MemWrite_o, stall_o, misalign_o;
    logic [31:0] mem_read_data_o, alu_result_o, store_data_o;
    logic [4:0] write_reg_o;
    always #5 clk = ~clk;
    mem_access_stage_if #(.ADDR_W(32)) dmem ();
    mem_access_stage dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .alu_result(alu_result), .store_data(store_data), .write_reg(write_reg), .dmem(dmem),
        .MemToReg_o(MemToReg_o), .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o),
        .mem_read_data_o(mem_read_data_o), .alu_result_o(alu_result_o), .write_reg_o(write_reg_o),
        .store_data_o(store_data_o), .stall_o(stall_o), .misalign_o(misalign_o)
    );
    typedef struct {
        logic rw, mtr, mw;
        logic [31:0] rd, alu;
        logic [4:0] wr;
    } exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic ev, rd, wr, mtr, rw, input logic [1:0] sz, input logic uns,
                         input logic [31:0] alu, sd, input logic [4:0] wreg);
        ex_valid = ev; MemRead = rd; MemWrite = wr; MemToReg = mtr; RegWrite = rw;
        mem_size = sz; mem_unsigned = uns; alu_result = alu; store_data = sd; write_reg = wreg;
    endtask
    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".RegWrite_o"}, 32'(RegWrite_o), 32'(e.rw));
            chk({tag, ".MemToReg_o"}, 32'(MemToReg_o), 32'(e.mtr));
            chk({tag, ".MemWrite_o"}, 32'(MemWrite_o), 32'(e.mw));
            chk({tag, ".mem_read_data_o"}, mem_read_data_o, e.rd);
            chk({tag, ".alu_result_o"}, alu_result_o, e.alu);
            chk({tag, ".write_reg_o"}, 32'(write_reg_o), 32'(e.wr));
        end
    endtask
    // Aligned access: gnt arrives gd cycles after the request, rvalid the cycle after the grant.
    task automatic mem_access(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, sd, rdat, input int gd,
                              input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
        int stalls;
        @(negedge clk);
        drive(1'b1, ~wr, wr, ~wr, ~wr, sz, uns, addr, sd, 5'd7);
        sb.push_back('{rw: ~wr, mtr: ~wr, mw: wr, rd: erd, alu: addr, wr: 5'd7});
        dmem.dmem_gnt = (gd == 0);
        dmem.dmem_rvalid = 1'b0;
        #1;
        stalls = int'(stall_o);
        chk({tag, ".req"}, 32'(dmem.dmem_req), 32'd1);
        chk({tag, ".we"}, 32'(dmem.dmem_we), 32'(wr));
        chk({tag, ".addr"}, dmem.dmem_addr, {addr[31:2], 2'b00});
        chk({tag, ".be"}, 32'(dmem.dmem_be), 32'(ebe));
        chk({tag, ".wdata"}, dmem.dmem_wdata, ewd);
        chk({tag, ".bubble_rw"}, 32'(RegWrite_o), 32'd0);
        for (int k = 1; k <= gd; k++) begin
            @(negedge clk);
            dmem.dmem_gnt = (k == gd);
            #1;
            stalls += int'(stall_o);
            chk({tag, ".req_hold"}, 32'(dmem.dmem_req), 32'd1);
            chk({tag, ".addr_hold"}, dmem.dmem_addr, {addr[31:2], 2'b00});
            chk({tag, ".be_hold"}, 32'(dmem.dmem_be), 32'(ebe));
            chk({tag, ".wdata_hold"}, dmem.dmem_wdata, ewd);
            chk({tag, ".bubble_mw"}, 32'(MemWrite_o), 32'd0);
        end
        @(negedge clk);
        dmem.dmem_gnt = 1'b0;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata = rdat;
        #1;
        stalls += int'(stall_o);
        chk({tag, ".wait_req"}, 32'(dmem.dmem_req), 32'd0);
        @(negedge clk);
        dmem.dmem_rvalid = 1'b0;
        dmem.dmem_rdata = 32'h5a5a5a5a;
        #1;
        for (int n = 0; n < 8 && stall_o; n++) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        chk({tag, ".stall_cycles"}, 32'(stalls), 32'(gd + 2));
        pop_check(tag);
        @(negedge clk);
        ex_valid = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h1234, 32'h0, 5'd5);
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = 32'h0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst.stall", 32'(stall_o), 32'd0);
        chk("rst.req", 32'(dmem.dmem_req), 32'd0);
        chk("rst.RegWrite_o", 32'(RegWrite_o), 32'd0);
        chk("rst.alu_result_o", alu_result_o, 32'd0);
        chk("rst.write_reg_o", 32'(write_reg_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h1234, 32'hAA, 5'd5);
        sb.push_back('{rw: 1'b1, mtr: 1'b0, mw: 1'b0, rd: 32'h0, alu: 32'h1234, wr: 5'd5});
        #1;
        chk("alu.stall", 32'(stall_o), 32'd0);
        chk("alu.req", 32'(dmem.dmem_req), 32'd0);
        pop_check("alu");
        mem_access("lw", 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'hf, 32'h0, 32'hDEADBEEF);
        mem_access("lb", 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 4'hf, 32'h0, 32'hFFFFFF80);
        mem_access("lbu", 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 1, 4'hf, 32'h0, 32'h00000080);
        mem_access("lh", 1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, 32'h80011234, 0, 4'hf, 32'h0, 32'hFFFF8001);
        mem_access("sh", 1'b1, SZ_HALF, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 3, 4'b1100, 32'hABCDABCD, 32'h0);
        mem_access("sb", 1'b1, SZ_BYTE, 1'b0, 32'h301, 32'h000000C3, 32'h0, 2, 4'b0010, 32'hC3C3C3C3, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h101, 32'h0, 5'd9);
        #1;
        chk("mis.misalign_o", 32'(misalign_o), 32'd1);
        chk("mis.req", 32'(dmem.dmem_req), 32'd0);
        chk("mis.RegWrite_o", 32'(RegWrite_o), 32'd0);
        chk("mis.stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("mis.one_cycle", 32'(misalign_o), 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h0, 5'd3);
        dmem.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem.dmem_gnt = 1'b0;
        #1;
        chk("rwait.stall_before", 32'(stall_o), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rwait.rst_stall", 32'(stall_o), 32'd0);
        chk("rwait.rst_alu_o", alu_result_o, 32'd0);
        reset = 1'b0;
        ex_valid = 1'b0;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata = 32'h12345678;
        #1;
        chk("rwait.stray_stall", 32'(stall_o), 32'd0);
        chk("rwait.stray_req", 32'(dmem.dmem_req), 32'd0);
        @(negedge clk);
        dmem.dmem_rvalid = 1'b0;
        #1;
        chk("rwait.no_done_rd", mem_read_data_o, 32'd0);
        chk("rwait.no_done_rw", 32'(RegWrite_o), 32'd0);
        chk("rwait.stall_after", 32'(stall_o), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage between the EX/MEM pipeline register and the MEM/WB register.
- Issues load/store requests to a variable-latency data memory over a req/gnt/rvalid handshake.
- Freezes upstream stages with stall_o while an access is in flight, then presents one completed instruction (controls, aligned load data, ALU result) to the MEM/WB register.
- Handles byte/half/word sizes, sign extension and misalignment detection.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ex_valid  in  1  EX/MEM holds a real instruction
- MemRead  in  1  load instruction
- MemWrite  in  1  store instruction
- MemToReg  in  1  writeback selects memory data
- RegWrite  in  1  instruction writes the register file
- mem_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- mem_unsigned  in  1  zero-extend loads (lbu/lhu)
- alu_result  in  32  effective address or ALU value
- store_data  in  32  rt value for stores
- write_reg  in  5  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  request is a write
- dmem_addr  out  ADDR_W  word-aligned address, alu_result with [1:0]=0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  response or write acknowledge
- dmem_rdata  in  32  read word
- MemToReg_o, RegWrite_o, MemWrite_o  out  1 each  controls to MEM/WB
- mem_read_data_o  out  32  extended load data
- alu_result_o  out  32  alu_result passthrough
- write_reg_o  out  5  write_reg passthrough
- store_data_o  out  32  lane-aligned store data
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- misalign_o  out  1  one-cycle misaligned-access flag

Behaviour:
- Clocking and reset:
  - reset: synchronous, active-high. clk: clock.
  - On reset, FSM goes to IDLE, rdata_q=0, and any outstanding response is discarded.
  - While reset is high, every output is 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- Non-memory instruction, or ex_valid=0:
  - Stays in IDLE; zero-latency combinational passthrough.
  - mem_read_data_o=0, stall_o=0, dmem_req=0.
- Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0):
  - No request is issued; misalign_o=1 for that cycle.
  - RegWrite_o=0 and MemWrite_o=0, i.e. a bubble.
  - stall_o=0 and the FSM stays in IDLE.
- Aligned memory op in IDLE:
  - dmem_req=1 and stall_o=1 in the same cycle.
  - If dmem_gnt=1, go to WAIT; otherwise go to REQ.
- REQ:
  - dmem_req=1; addr/we/be/wdata are held stable; stall_o=1.
  - On dmem_gnt, go to WAIT.
- WAIT:
  - dmem_req=0, stall_o=1.
  - On dmem_rvalid, capture dmem_rdata into rdata_q and go to DONE.
  - rvalid is never sampled in the grant cycle.
- DONE:
  - stall_o=0; outputs carry the instruction's controls, and mem_read_data_o is extracted from rdata_q.
  - Next state is IDLE unconditionally.
- Bubbles while stalled: in every stalled cycle (IDLE-with-req, REQ, WAIT), RegWrite_o=0, MemWrite_o=0 and MemToReg_o=0, so MEM/WB captures a bubble.
- Minimum memory-op latency is 3 cycles: gnt in the IDLE cycle, rvalid in the next cycle, DONE in the cycle after.
- Store lanes:
  - Byte: be = 1<<addr[1:0], wdata = byte replicated x4.
  - Half: be = 0011 if addr[1]=0, else 1100; wdata = half replicated x2.
  - Word: be = 1111.
  - Loads drive be=1111.
- Load extract: rdata_q >> (8*addr[1:0]), then truncate to size, then sign-extend unless mem_unsigned.
- Input stability: upstream holds all inputs stable while stall_o=1. Behaviour is undefined if the inputs change mid-access.
- Reset mid-access (REQ or WAIT): return to IDLE and drop req; a later stray rvalid is ignored in IDLE.

Decomposition:
- Shared package mips_pkg holds:
  - the mem_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the FSM state enum;
  - the DATA_W constant.
- One sub-module, mem_lane_align (combinational), provides:
  - store lane alignment and byte enables;
  - load extraction and extension;
  - misalignment detection.

Test Plan:
- ALU-only op: RegWrite=1, alu_result=0x1234, write_reg=5 -> same-cycle passthrough, stall_o=0, dmem_req=0.
- lw at 0x100 with gnt immediate, rvalid next cycle with rdata=0xDEADBEEF:
  - stall_o=1 for 2 cycles;
  - DONE shows mem_read_data_o=0xDEADBEEF, RegWrite_o=1, MemToReg_o=1.
- lb at 0x103, rdata=0x80FFFFFF:
  - mem_unsigned=0 -> mem_read_data_o=0xFFFFFF80;
  - mem_unsigned=1 -> 0x00000080.
- sh at 0x202, store_data=0x0000ABCD, gnt delayed 3 cycles -> dmem_be=1100, wdata=0xABCDABCD, addr=0x200, all held stable through REQ.
- lw at 0x101 -> misalign_o=1 for 1 cycle, dmem_req=0, RegWrite_o=0, stall_o=0.
- reset asserted in WAIT, then rvalid arrives -> FSM in IDLE, outputs 0, rdata_q remains 0, no DONE pulse.
